// File: rtl/bkm_digit_gen.sv
// BKM signed-digit generator: splits a complex fixed-point operand into a stream
// of radix-2 digit pairs in {-1,0,+1}, one pair per ready/valid beat.

module bkm_digit_lane #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] r_init,
   output logic [1:0]   dig,
   output logic [W-1:0] r_nxt
);
   localparam logic signed [W-1:0] THR   = W'(1) << (W-2);
   localparam logic signed [W-1:0] NTHR  = -THR;
   localparam logic signed [W+1:0] TWO_W = {2'b01, {W{1'b0}}};

   logic [W-1:0]        r;
   logic signed [W+1:0] two_r;
   logic signed [W+1:0] upd;

   always_comb begin
      dig = 2'b00;
      if ($signed(r) >= THR)
         dig = 2'b01;
      else if ($signed(r) < NTHR)
         dig = 2'b11;
   end

   assign two_r = {r[W-1], r, 1'b0};

   always_comb begin
      upd = two_r;
      case (dig)
         2'b01:   upd = two_r - TWO_W;
         2'b11:   upd = two_r + TWO_W;
         default: upd = two_r;
      endcase
   end

   // digit selection keeps upd inside the W-bit range, so the cast drops only sign copies
   assign r_nxt = W'(upd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r <= '0;
      else if (load)
         r <= r_init;
      else if (step)
         r <= r_nxt;
   end
endmodule

module bkm_digit_gen #(
   parameter int W     = 8,
   parameter int N_DIG = 8,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic [W-1:0]     x_in,
   input  logic [W-1:0]     y_in,
   output logic             busy,
   output logic             dig_valid,
   input  logic             dig_ready,
   output logic [1:0]       d_x,
   output logic [1:0]       d_y,
   output logic [IDX_W-1:0] dig_idx,
   output logic             dig_last,
   output logic             done,
   output logic [W-1:0]     res_x,
   output logic [W-1:0]     res_y
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [1:0][W-1:0] r_init;
   logic [1:0][W-1:0] r_nxt;
   logic [1:0][1:0]   dig;
   logic [IDX_W-1:0]  n;
   logic              run, last, load, xfer;

   // lane 0 carries the real part, lane 1 the imaginary part
   assign r_init = {y_in, x_in};
   assign run    = (state == S_RUN);
   assign last   = run && (n == LAST_IDX);
   assign load   = ena && (state == S_IDLE) && start;
   assign xfer   = ena && run && dig_ready;

   generate
      for (genvar i = 0; i < 2; i++) begin : g_lane
         bkm_digit_lane #(.W(W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .step   (xfer),
            .r_init (r_init[i]),
            .dig    (dig[i]),
            .r_nxt  (r_nxt[i])
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (dig_ready && last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else if (ena)
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n     <= '0;
         res_x <= '0;
         res_y <= '0;
      end else if (load) begin
         n <= '0;
      end else if (xfer) begin
         if (last) begin
            n     <= '0;
            res_x <= r_nxt[0];
            res_y <= r_nxt[1];
         end else begin
            n <= n + IDX_W'(1);
         end
      end
   end

   // digits are forced to zero outside RUN so an idle residual never leaks out
   assign busy      = run;
   assign dig_valid = run;
   assign dig_last  = last;
   assign done      = (state == S_DONE);
   assign dig_idx   = n;
   assign d_x       = run ? dig[0] : 2'b00;
   assign d_y       = run ? dig[1] : 2'b00;
endmodule
